// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared types for the NCO clock-enable generator.
// Holds the FSM state encoding, the config write bundle and limits.
package clkgen_pkg;

  localparam int MAX_CLOCKS = 16;
  localparam int MAX_ACC_W  = 32;
  localparam int CHAN_W     = $clog2(MAX_CLOCKS);

  typedef enum logic [1:0] {
    CG_RESET  = 2'd0,
    CG_SETTLE = 2'd1,
    CG_LOCKED = 2'd2
  } cg_state_t;

  typedef struct packed {
    logic [CHAN_W-1:0]    chan;
    logic [MAX_ACC_W-1:0] inc;
    logic [MAX_ACC_W-1:0] phase;
  } cfg_t;

endpackage

// File: rtl/clkgen_nco_chan.sv
// clkgen_nco_chan: one NCO channel (inc/phase/acc, adder, ce, clk_o).
// run: accumulate; otherwise hold acc at phase. load: take new inc/phase.
module clkgen_nco_chan #(
  parameter int               ACC_W   = 16,
  parameter logic [ACC_W-1:0] RST_INC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
  input  logic [ACC_W-1:0] load_phase,
  output logic             ce,
  output logic             clk_o
);

  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] phase;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, inc};
  assign clk_o = acc[ACC_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc   <= RST_INC;
      phase <= '0;
      acc   <= '0;
      ce    <= 1'b0;
    end else begin
      if (load) begin
        inc   <= load_inc;
        phase <= load_phase;
      end
      if (run) begin
        acc <= sum[ACC_W-1:0];
        ce  <= sum[ACC_W];
      end else begin
        // new phase takes effect on the same edge it is written
        acc <= load ? load_phase : phase;
        ce  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clkgen_nco.sv
// clkgen_nco: runtime-programmable fractional clock-enable generator.
// Ports: refclk/rst_n, cfg_* write port, per-channel ce/clk_o, locked.
module clkgen_nco
  import clkgen_pkg::*;
#(
  parameter int          NUM_CLOCKS  = 3,
  parameter int          ACC_W       = 16,
  parameter int          LOCK_CYCLES = 16,
  parameter int unsigned DEFAULT_INC = 32'h2000
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [3:0]            cfg_chan,
  input  logic [ACC_W-1:0]      cfg_inc,
  input  logic [ACC_W-1:0]      cfg_phase,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] ce,
  output logic [NUM_CLOCKS-1:0] clk_o,
  output logic                  locked
);

  localparam int CNT_W =
    (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CHAN_W:0] NUM_CH =
    (CHAN_W + 1)'(NUM_CLOCKS);

  cg_state_t        state;
  logic [CNT_W-1:0] cnt;
  cfg_t             cfg;
  logic             cfg_take;
  logic             cfg_bad;
  logic             cfg_hit;
  logic             run;
  logic             unused_cfg;

  assign cfg.chan   = cfg_chan;
  assign cfg.inc    = MAX_ACC_W'(cfg_inc);
  assign cfg.phase  = MAX_ACC_W'(cfg_phase);
  assign unused_cfg = ^cfg;

  assign cfg_ready = (state != CG_RESET);
  assign locked    = (state == CG_LOCKED);
  assign cfg_take  = cfg_valid && cfg_ready;
  assign cfg_bad   = cfg_take && ({1'b0, cfg.chan} >= NUM_CH);
  assign cfg_hit   = cfg_take && !cfg_bad;
  // a valid write freezes every channel so all restart aligned
  assign run       = locked && !cfg_hit;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CG_RESET;
      cnt     <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_bad;
      unique case (state)
        CG_RESET: begin
          state <= CG_SETTLE;
          cnt   <= '0;
        end
        CG_SETTLE: begin
          if (cfg_hit)
            cnt <= '0;
          else if (cnt == CNT_LAST)
            state <= CG_LOCKED;
          else
            cnt <= cnt + 1'b1;
        end
        CG_LOCKED: begin
          if (cfg_hit) begin
            state <= CG_SETTLE;
            cnt   <= '0;
          end
        end
        default: state <= CG_RESET;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
    logic load;
    assign load = cfg_hit && (cfg.chan == CHAN_W'(i));
    clkgen_nco_chan #(
      .ACC_W   (ACC_W),
      .RST_INC (ACC_W'(DEFAULT_INC))
    ) u_chan (
      .clk        (refclk),
      .rst_n      (rst_n),
      .run        (run),
      .load       (load),
      .load_inc   (cfg.inc[ACC_W-1:0]),
      .load_phase (cfg.phase[ACC_W-1:0]),
      .ce         (ce[i]),
      .clk_o      (clk_o[i])
    );
  end

endmodule
